// File: rtl/ysyx_22041752_axi_sram_slave.sv
// AXI4 slave backed by one 64-bit wide SRAM array. The read and write
// channels run independent FSMs that share the array through one read
// port (feeding the registered R payload) and one byte-masked write port.
//
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid and ready are both 1; the source holds valid and its payload
// stable while valid && !ready, and ready never depends on valid.
module ysyx_22041752_axi_sram_slave #(
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int unsigned DEPTH = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [3:0]  rid,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast
);

    localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN       = 32'(DEPTH) * 32'd8;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLV   = 2'b10;
    localparam logic [1:0]  RESP_DEC   = 2'b11;
    localparam logic [1:0]  BURST_INCR = 2'b01;

    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [63:0] mem [DEPTH];

    // Byte address falls inside the array window (wrapping subtraction).
    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
        return IDX_W'((addr - BASE) >> 3);
    endfunction

    // Only INCR bursts of at most 8 bytes per beat are serviced.
    function automatic logic bad_burst(input logic [1:0] burst, input logic [2:0] size);
        return (burst != BURST_INCR) || (size > 3'd3);
    endfunction

    function automatic logic [31:0] beat_step(input logic [2:0] size);
        return 32'd1 << size;
    endfunction

    // ---------------- read channel ----------------
    r_state_e    r_state_q, r_state_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [2:0]  r_size_q, r_size_d;
    logic [1:0]  r_burst_q, r_burst_d;
    logic [7:0]  r_beat_q, r_beat_d;
    logic        rvalid_q, rvalid_d;
    logic [3:0]  rid_q, rid_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;

    logic [31:0] rd_addr;
    logic        rd_bad;
    logic [63:0] rd_word;
    logic [1:0]  rd_resp;
    logic [63:0] rd_data;

    // Address, response and data of the beat that the next edge will load.
    always_comb begin
        if (r_state_q == R_IDLE) begin
            rd_addr = araddr;
            rd_bad  = bad_burst(arburst, arsize);
        end else begin
            rd_addr = r_addr_q + beat_step(r_size_q);
            rd_bad  = bad_burst(r_burst_q, r_size_q);
        end
        rd_word = mem[word_index(rd_addr)];
        if (!in_range(rd_addr)) begin
            rd_resp = RESP_DEC;
            rd_data = 64'd0;
        end else if (rd_bad) begin
            rd_resp = RESP_SLV;
            rd_data = 64'd0;
        end else begin
            rd_resp = RESP_OKAY;
            rd_data = rd_word;
        end
    end

    // Read FSM next state: accept AR in idle, stream beats without bubbles.
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_beat_d  = r_beat_q;
        rvalid_d  = rvalid_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    r_state_d = R_DATA;
                    r_addr_d  = araddr;
                    r_len_d   = arlen;
                    r_size_d  = arsize;
                    r_burst_d = arburst;
                    r_beat_d  = 8'd0;
                    rvalid_d  = 1'b1;
                    rid_d     = arid;
                    rdata_d   = rd_data;
                    rresp_d   = rd_resp;
                    rlast_d   = (arlen == 8'd0);
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        r_addr_d = rd_addr;
                        r_beat_d = r_beat_q + 8'd1;
                        rdata_d  = rd_data;
                        rresp_d  = rd_resp;
                        rlast_d  = ((r_beat_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= 32'd0;
            r_len_q   <= 8'd0;
            r_size_q  <= 3'd0;
            r_burst_q <= 2'd0;
            r_beat_q  <= 8'd0;
            rvalid_q  <= 1'b0;
            rid_q     <= 4'd0;
            rdata_q   <= 64'd0;
            rresp_q   <= 2'd0;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_beat_q  <= r_beat_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

    // ---------------- write channel ----------------
    w_state_e    w_state_q, w_state_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [2:0]  w_size_q, w_size_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic [7:0]  w_beat_q, w_beat_d;
    logic        w_dec_q, w_dec_d;
    logic        w_slv_q, w_slv_d;
    logic        bvalid_q, bvalid_d;
    logic [3:0]  bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;

    logic             w_hs;
    logic             w_in_range;
    logic             w_beat_last;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;

    // Write FSM next state: errors accumulate over the burst, response at the end.
    always_comb begin
        w_state_d   = w_state_q;
        w_addr_d    = w_addr_q;
        w_len_d     = w_len_q;
        w_size_d    = w_size_q;
        w_burst_d   = w_burst_q;
        w_beat_d    = w_beat_q;
        w_dec_d     = w_dec_q;
        w_slv_d     = w_slv_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        w_hs        = (w_state_q == W_DATA) && wvalid;
        w_in_range  = in_range(w_addr_q);
        w_beat_last = (w_beat_q == w_len_q);
        wr_en       = w_hs && w_in_range && !bad_burst(w_burst_q, w_size_q);
        wr_idx      = word_index(w_addr_q);
        case (w_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    w_state_d = W_DATA;
                    w_addr_d  = awaddr;
                    w_len_d   = awlen;
                    w_size_d  = awsize;
                    w_burst_d = awburst;
                    w_beat_d  = 8'd0;
                    w_dec_d   = 1'b0;
                    w_slv_d   = bad_burst(awburst, awsize);
                    bid_d     = awid;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    w_dec_d  = w_dec_q | ~w_in_range;
                    w_slv_d  = w_slv_q | (wlast != w_beat_last);
                    w_addr_d = w_addr_q + beat_step(w_size_q);
                    w_beat_d = w_beat_q + 8'd1;
                    if (wlast || w_beat_last) begin
                        w_state_d = W_RESP;
                        bvalid_d  = 1'b1;
                        bresp_d   = w_dec_d ? RESP_DEC : (w_slv_d ? RESP_SLV : RESP_OKAY);
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM registers; reset drops the burst without issuing B.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= 32'd0;
            w_len_q   <= 8'd0;
            w_size_q  <= 3'd0;
            w_burst_q <= 2'd0;
            w_beat_q  <= 8'd0;
            w_dec_q   <= 1'b0;
            w_slv_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 4'd0;
            bresp_q   <= 2'd0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_beat_q  <= w_beat_d;
            w_dec_q   <= w_dec_d;
            w_slv_q   <= w_slv_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Byte-masked write port; array contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wstrb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign awready = (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_22041752_axi_sram_slave.sv
// Bench for the AXI SRAM slave: directed scenarios plus randomized bursts,
// all checked against a word-array memory model and per-beat AXI rules.
module tb_ysyx_22041752_axi_sram_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] SPAN  = 32'd32768;

    logic        clk;
    logic        reset;
    logic        awvalid, awready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    ysyx_22041752_axi_sram_slave #(.BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference memory: word contents plus whether every byte is defined.
    logic [63:0] mdl [DEPTH];
    bit          known [DEPTH];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    logic [63:0] exp_q[$];
    logic [1:0]  resp_q[$];
    bit          known_q[$];

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a - BASE) < SPAN;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    task automatic model_write(input int i, input logic [63:0] d, input logic [7:0] s);
        for (int l = 0; l < 8; l++) begin
            if (s[l]) mdl[i][8*l +: 8] = d[8*l +: 8];
        end
        if (s == 8'hFF) known[i] = 1'b1;
    endtask

    // Driver tasks: entered and left on a falling edge.
    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("ar_accept", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        check("aw_accept", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    // mode 0: rready always 1, mode 1: toggles 1,0,1..., otherwise random.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
        logic [31:0] a;
        bit          bad;
        int          beat;
        int          k;
        a = addr;
        bad = (burst != 2'b01) || (size > 3'd3);
        for (int i = 0; i <= int'(len); i++) begin
            if (!addr_ok(a)) begin
                exp_q.push_back(64'd0); resp_q.push_back(2'b11); known_q.push_back(1'b1);
            end else if (bad) begin
                exp_q.push_back(64'd0); resp_q.push_back(2'b10); known_q.push_back(1'b1);
            end else begin
                exp_q.push_back(mdl[widx(a)]); resp_q.push_back(2'b00); known_q.push_back(known[widx(a)]);
            end
            a = a + (32'd1 << size);
        end
        send_ar(id, addr, len, size, burst);
        check("r_first_lat", rvalid, 1);
        beat = 0;
        k = 0;
        while (beat <= int'(len) && k < 2000) begin
            if (mode == 0) rready = 1'b1;
            else if (mode == 1) rready = (k % 2 == 0);
            else rready = ($urandom_range(0, 3) != 0);
            check("r_valid", rvalid, 1);
            if (!rvalid) break;
            check("r_id", rid, id);
            check("r_resp", rresp, resp_q[0]);
            if (known_q[0]) check("r_data", rdata, exp_q[0]);
            check("r_last", rlast, (beat == int'(len)));
            if (rready) begin
                void'(exp_q.pop_front());
                void'(resp_q.pop_front());
                void'(known_q.pop_front());
                beat++;
            end
            k++;
            @(negedge clk);
        end
        rready = 1'b0;
        check("r_done_idle", {rvalid, arready}, 2'b01);
        exp_q.delete();
        resp_q.delete();
        known_q.delete();
    endtask

    // Data and strobes come from wd/ws; wlast is driven on beat last_beat.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int last_beat);
        logic [31:0] a;
        bit          bad;
        bit          dec;
        bit          slv;
        bit          wl;
        int          nb;
        int          n;
        logic [1:0]  eb;
        a = addr;
        bad = (burst != 2'b01) || (size > 3'd3);
        dec = 1'b0;
        slv = bad;
        nb = 0;
        for (int b = 0; b <= int'(len); b++) begin
            wl = (b == last_beat);
            if (!addr_ok(a)) dec = 1'b1;
            else if (!bad) model_write(widx(a), wd[b], ws[b]);
            if (wl != (b == int'(len))) slv = 1'b1;
            a = a + (32'd1 << size);
            nb++;
            if (wl) break;
        end
        eb = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
        send_aw(id, addr, len, size, burst);
        for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(negedge clk);
            end
            wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = (b == last_beat);
            n = 0;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            check("w_ready", wready, 1);
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check("b_valid", bvalid, 1);
        check("b_resp", bresp, eb);
        check("b_id", bid, id);
        if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            check("b_hold", {bvalid, bresp, bid}, {1'b1, eb, id});
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("w_done_idle", {awready, bvalid, wready}, 3'b100);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {arready, awready, wready}, 3'b110);
        check({tag, "_valid"}, {rvalid, bvalid, rlast}, 3'b000);
        check({tag, "_ids"}, {rid, bid, rresp, bresp}, 12'h000);
        check({tag, "_rdata"}, rdata, 64'd0);
    endtask

    // Stimulus and scoreboard
    initial begin
        logic [63:0] old_v;
        logic [63:0] new_v;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          hs;
        int          n;
        int          lb;

        reset = 1'b1;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        for (int i = 0; i < DEPTH; i++) begin mdl[i] = 64'd0; known[i] = 1'b0; end
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_init");
        reset = 1'b0;
        @(negedge clk);

        // preload words 0..63 and the top word
        for (int g = 0; g < 8; g++) begin
            for (int b = 0; b < 8; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
            do_write(4'(g), BASE + 32'(64 * g), 8'd7, 3'd3, 2'b01, 7);
        end
        wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
        do_write(4'h1, BASE + SPAN - 32'd8, 8'd0, 3'd3, 2'b01, 0);

        // single-beat write then read back
        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        do_write(4'h3, BASE, 8'd0, 3'd3, 2'b01, 0);
        do_read(4'h3, BASE, 8'd0, 3'd3, 2'b01, 0);

        // 8-beat read with rready toggling
        do_read(4'h5, BASE + 32'h40, 8'd7, 3'd3, 2'b01, 1);

        // partial strobe merge
        wd[0] = 64'hAAAAAAAA_BBBBBBBB; ws[0] = 8'h0F;
        do_write(4'h2, BASE, 8'd0, 3'd3, 2'b01, 0);
        do_read(4'h2, BASE, 8'd0, 3'd3, 2'b01, 0);

        // crossing into the window from below, early wlast
        do_read(4'h7, 32'h7FFF_FFF8, 8'd1, 3'd3, 2'b01, 0);
        for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
        do_write(4'h9, BASE + 32'h100, 8'd3, 3'd3, 2'b01, 1);
        do_read(4'h9, BASE + 32'h100, 8'd3, 3'd3, 2'b01, 2);

        // leaving the window at the top, missing wlast, bad burst and size
        do_read(4'h1, BASE + SPAN - 32'd8, 8'd1, 3'd3, 2'b01, 2);
        for (int b = 0; b < 2; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
        do_write(4'hA, BASE + SPAN - 32'd8, 8'd1, 3'd3, 2'b01, 1);
        do_read(4'hA, BASE + SPAN - 32'd8, 8'd0, 3'd3, 2'b01, 0);
        for (int b = 0; b < 3; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
        do_write(4'hB, BASE + 32'h20, 8'd2, 3'd3, 2'b01, 3);
        do_write(4'hC, BASE + 32'h40, 8'd0, 3'd3, 2'b00, 0);
        do_write(4'hD, BASE + 32'h48, 8'd0, 3'd4, 2'b01, 0);
        do_read(4'hE, BASE + 32'h40, 8'd2, 3'd3, 2'b00, 0);
        do_read(4'hF, BASE + 32'h40, 8'd1, 3'd4, 2'b01, 0);
        do_read(4'h0, BASE + 32'h40, 8'd2, 3'd3, 2'b01, 0);

        // reset during beat 3 of an 8-beat read
        send_ar(4'h4, BASE, 8'd7, 3'd3, 2'b01);
        rready = 1'b1;
        hs = 0;
        n = 0;
        while (hs < 3 && n < 50) begin
            if (rvalid) hs++;
            @(negedge clk);
            n++;
        end
        check("rst_mid_valid", rvalid, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        rready = 1'b0;
        @(negedge clk);
        do_read(4'h6, BASE + 32'h80, 8'd3, 3'd3, 2'b01, 0);

        // AR and AW accepted on the same edge to the same word
        old_v = mdl[20];
        new_v = {$urandom, $urandom};
        arvalid = 1'b1; arid = 4'h2; araddr = BASE + 32'd160; arlen = 0; arsize = 3; arburst = 2'b01;
        awvalid = 1'b1; awid = 4'h6; awaddr = BASE + 32'd160; awlen = 0; awsize = 3; awburst = 2'b01;
        check("dual_ready", {arready, awready}, 2'b11);
        @(negedge clk);
        arvalid = 1'b0;
        awvalid = 1'b0;
        check("dual_rvalid", {rvalid, wready}, 2'b11);
        check("dual_old", rdata, old_v);
        wvalid = 1'b1; wdata = new_v; wstrb = 8'hFF; wlast = 1'b1; rready = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
        check("dual_b", {bvalid, bresp, bid}, {1'b1, 2'b00, 4'h6});
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        model_write(20, new_v, 8'hFF);
        do_read(4'h3, BASE + 32'd160, 8'd0, 3'd3, 2'b01, 0);

        // read loaded on the same edge as the write of that word
        old_v = mdl[21];
        new_v = {$urandom, $urandom};
        send_aw(4'h8, BASE + 32'd168, 8'd0, 3'd3, 2'b01);
        wvalid = 1'b1; wdata = new_v; wstrb = 8'hFF; wlast = 1'b1;
        arvalid = 1'b1; arid = 4'h1; araddr = BASE + 32'd168; arlen = 0; arsize = 3; arburst = 2'b01;
        check("same_edge_ready", {arready, wready}, 2'b11);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        check("same_edge_rvalid", {rvalid, bvalid}, 2'b11);
        check("same_edge_old", rdata, old_v);
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        check("same_edge_idle", {arready, awready, rvalid, bvalid}, 4'b1100);
        model_write(21, new_v, 8'hFF);
        do_read(4'h1, BASE + 32'd168, 8'd0, 3'd3, 2'b01, 0);

        // randomized traffic inside words 0..63
        for (int t = 0; t < 40; t++) begin
            len   = 8'($urandom_range(0, 7));
            size  = ($urandom_range(0, 7) == 0) ? 3'd4 : 3'($urandom_range(2, 3));
            burst = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
            addr  = BASE + 32'(8 * $urandom_range(0, 48));
            if (size == 3'd2 && $urandom_range(0, 1) == 1) addr = addr + 32'd4;
            if ($urandom_range(0, 1) == 1) begin
                do_read(4'($urandom), addr, len, size, burst, 2);
            end else begin
                for (int b = 0; b < 8; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'($urandom); end
                lb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(len) + 1)) : int'(len);
                do_write(4'($urandom), addr, len, size, burst, lb);
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
